smb_serial_tx: RTL and testbench

Serial message transmitter for the port-steered serial link. It is the sending end for the receive-side bit steering logic. It accepts 4-bit messages from four parallel ports, arbitrates between pending ports round-robin, and shifts each message onto a single serial line as a framed word: start bit, 2-bit port number, 4 data bits. It also drives the `PB`/`LB` steering view of the bit currently on the line, so a loopback into the receiver reproduces the source port's data.

---
 rtl/smb_pkg.sv | 29 ++
 rtl/smb_rr_arbiter.sv | 51 +++++
 rtl/smb_serial_tx.sv | 188 ++++++++++++++++++
 tb/tb_smb_serial_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/smb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : smb_pkg                                                 |
// | Brief    : Shared types, constants and helpers for the serial TX.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package smb_pkg;

  localparam int SMB_NPORT = 4;
  localparam int SMB_DW    = 4;
  localparam int SMB_AW    = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4
  } smb_tx_state_t;

  function automatic logic [SMB_NPORT-1:0] smb_onehot(input logic [SMB_AW-1:0] idx);
    logic [SMB_NPORT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/smb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : smb_rr_arbiter                                          |
// | Brief    : 4-way round-robin arbiter, pointer advances on grant.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module smb_rr_arbiter
  import smb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SMB_NPORT-1:0] i_req,
  input  logic                 i_en,
  output logic                 o_vld,
  output logic [SMB_NPORT-1:0] o_gnt,
  output logic [SMB_AW-1:0]    o_idx
);

  logic [SMB_AW-1:0] r_last;
  logic [SMB_AW-1:0] w_cand;
  logic [SMB_AW-1:0] w_idx;
  logic              w_found;

  // Search begins one past the last winner, so the last winner is checked last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 1; i <= SMB_NPORT; i++) begin
      w_cand = r_last + SMB_AW'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign o_vld = w_found;
  assign o_idx = w_idx;
  assign o_gnt = w_found ? smb_onehot(w_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= SMB_AW'(SMB_NPORT - 1);
    end else if (i_en && w_found) begin
      r_last <= w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/smb_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : smb_serial_tx                                           |
// | Brief    : Round-robin 4-port framed serial transmitter with PB/LB |
// |            steering view of the bit on the line.                   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module smb_serial_tx
  import smb_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SMB_NPORT-1:0] req,
  input  logic [SMB_DW-1:0]    L0,
  input  logic [SMB_DW-1:0]    L1,
  input  logic [SMB_DW-1:0]    L2,
  input  logic [SMB_DW-1:0]    L3,
  output logic [SMB_NPORT-1:0] ack,
  output logic                 serout,
  output logic                 busy,
  output logic [SMB_NPORT-1:0] PB,
  output logic [SMB_AW-1:0]    LB
);

  localparam logic [2:0] c_gap_last = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  smb_tx_state_t r_state;
  smb_tx_state_t w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;

  logic [SMB_AW+SMB_DW-1:0] r_shreg;
  logic [SMB_AW-1:0]        r_port;

  logic                 w_vld;
  logic [SMB_NPORT-1:0] w_gnt;
  logic [SMB_AW-1:0]    w_idx;
  logic                 w_grant;
  logic [SMB_DW-1:0]    w_lsel;

  logic                 w_serout_d;
  logic                 w_busy_d;
  logic [SMB_NPORT-1:0] w_ack_d;
  logic [SMB_NPORT-1:0] w_pb_d;
  logic [SMB_AW-1:0]    w_lb_d;

  logic                 r_serout;
  logic                 r_busy;
  logic [SMB_NPORT-1:0] r_ack;
  logic [SMB_NPORT-1:0] r_pb;
  logic [SMB_AW-1:0]    r_lb;

  smb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (req),
    .i_en  (r_state == IDLE),
    .o_vld (w_vld),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_grant = (r_state == IDLE) && w_vld;

  always_comb begin
    case (w_idx)
      2'd0:    w_lsel = L0;
      2'd1:    w_lsel = L1;
      2'd2:    w_lsel = L2;
      default: w_lsel = L3;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state logic; the counter restarts on every state change
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = START;
          w_cnt_nxt   = 3'd0;
        end
      end
      START: begin
        w_state_nxt = ADDR;
        w_cnt_nxt   = 3'd0;
      end
      ADDR: begin
        if (r_cnt == 3'(SMB_AW - 1)) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      DATA: begin
        if (r_cnt == 3'(SMB_DW - 1)) begin
          w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Shift register holds {port[1:0], d0, d1, d2, d3} so the MSB is always the next bit out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_port  <= '0;
    end else if (w_grant) begin
      r_shreg <= {w_idx, w_lsel[0], w_lsel[1], w_lsel[2], w_lsel[3]};
      r_port  <= w_idx;
    end else if (w_state_nxt == ADDR || w_state_nxt == DATA) begin
      r_shreg <= {r_shreg[SMB_AW+SMB_DW-2:0], 1'b0};
    end
  end

  // FSM output logic, evaluated one cycle ahead so every port is a flop
  always_comb begin
    w_serout_d = 1'b0;
    w_busy_d   = (w_state_nxt != IDLE);
    w_ack_d    = w_grant ? w_gnt : '0;
    w_pb_d     = '0;
    w_lb_d     = '0;
    case (w_state_nxt)
      START: w_serout_d = 1'b1;
      ADDR:  w_serout_d = r_shreg[SMB_AW+SMB_DW-1];
      DATA: begin
        w_serout_d = r_shreg[SMB_AW+SMB_DW-1];
        w_pb_d     = smb_onehot(r_port);
        w_lb_d     = w_cnt_nxt[SMB_AW-1:0];
      end
      default: w_serout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_serout <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
      r_pb     <= '0;
      r_lb     <= '0;
    end else begin
      r_serout <= w_serout_d;
      r_busy   <= w_busy_d;
      r_ack    <= w_ack_d;
      r_pb     <= w_pb_d;
      r_lb     <= w_lb_d;
    end
  end

  assign serout = r_serout;
  assign busy   = r_busy;
  assign ack    = r_ack;
  assign PB     = r_pb;
  assign LB     = r_lb;

endmodule
`default_nettype wire

// File: tb/tb_smb_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_smb_serial_tx                                        |
// | Brief    : Directed + random bench for smb_serial_tx with a frame  |
// |            and round-robin reference model.                        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_smb_serial_tx;

  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, reqz;
  logic [3:0] L0, L1, L2, L3;
  logic [3:0] ack, PB, ackz, PBz;
  logic [1:0] LB, LBz;
  logic       serout, busy, seroutz, busyz;

  int checks   = 0;
  int failures = 0;
  int rr_last;
  logic [3:0] ld [4];

  always #5 clk = ~clk;

  smb_serial_tx #(.GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .L0(L0), .L1(L1), .L2(L2), .L3(L3),
    .ack(ack), .serout(serout), .busy(busy), .PB(PB), .LB(LB)
  );

  smb_serial_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(reqz), .L0(L0), .L1(L1), .L2(L2), .L3(L3),
    .ack(ackz), .serout(seroutz), .busy(busyz), .PB(PBz), .LB(LBz)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_l();
    L0 = ld[0]; L1 = ld[1]; L2 = ld[2]; L3 = ld[3];
  endtask

  task automatic scramble_l();
    for (int i = 0; i < 4; i++) ld[i] = 4'($urandom);
    drive_l();
  endtask

  // Round-robin rule: first pending port after the last served one.
  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(rr_last + k) % 4]) return (rr_last + k) % 4;
    end
    return 0;
  endfunction

  // Line bits in transmission order: start, addr MSB, addr LSB, data LSB..MSB.
  function automatic logic [6:0] frame_bits(input int p, input logic [3:0] d);
    logic [6:0] f;
    f[0] = 1'b1;
    f[1] = p[1];
    f[2] = p[0];
    for (int i = 0; i < 4; i++) f[3+i] = d[i];
    return f;
  endfunction

  // Called in an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_frame(input logic [3:0] r, input logic [3:0] hold, input bit scr,
                          input string tag);
    int p;
    logic [3:0] d, oh;
    logic [6:0] fb;
    req = r;
    drive_l();
    p       = rr_pick(r);
    d       = ld[p];
    rr_last = p;
    fb      = frame_bits(p, d);
    oh      = 4'b0001 << p;
    tick();
    req = hold;
    if (scr) scramble_l();
    for (int j = 0; j < 7; j++) begin
      chk({tag, "_ser"},  8'(serout), 8'(fb[j]));
      chk({tag, "_busy"}, 8'(busy),   8'd1);
      chk({tag, "_ack"},  8'(ack),    (j == 0) ? 8'(oh) : 8'd0);
      chk({tag, "_pb"},   8'(PB),     (j >= 3) ? 8'(oh) : 8'd0);
      chk({tag, "_lb"},   8'(LB),     (j >= 3) ? 8'(j - 3) : 8'd0);
      if (j < 6) tick();
    end
    for (int g = 0; g < G; g++) begin
      tick();
      chk({tag, "_gap_ser"},  8'(serout), 8'd0);
      chk({tag, "_gap_busy"}, 8'(busy),   8'd1);
      chk({tag, "_gap_pb"},   8'(PB),     8'd0);
    end
    tick();
    chk({tag, "_idle_busy"}, 8'(busy),   8'd0);
    chk({tag, "_idle_ser"},  8'(serout), 8'd0);
    chk({tag, "_idle_ack"},  8'(ack),    8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [3:0] d, oh;
    logic [6:0] fb;

    rst = 1'b0; req = 4'd0; reqz = 4'd0; rr_last = 3;
    scramble_l();
    repeat (3) tick();
    chk("rst_ser",  8'(serout), 8'd0);
    chk("rst_busy", 8'(busy),   8'd0);
    chk("rst_ack",  8'(ack),    8'd0);
    chk("rst_pb",   8'(PB),     8'd0);
    chk("rst_lb",   8'(LB),     8'd0);
    chk("rst_busy0", 8'(busyz), 8'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 8'(busy), 8'd0);

    ld[0] = 4'b0110;
    do_frame(4'b0001, 4'b0000, 1'b0, "tp1");
    ld[2] = 4'b1011;
    do_frame(4'b0100, 4'b0000, 1'b0, "tp2");

    // Single-cycle request, data changed right after grant: one frame only.
    do_frame(4'b0010, 4'b0000, 1'b1, "pulse");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pulse_nosecond_busy", 8'(busy), 8'd0);
      chk("pulse_nosecond_ser",  8'(serout), 8'd0);
    end

    rst = 1'b0; #1; rst = 1'b1; rr_last = 3;
    tick();
    for (int f = 0; f < 5; f++) do_frame(4'b1111, 4'b1111, 1'b1, "all4");
    req = 4'b0000;
    tick();

    for (int n = 0; n < 10; n++)
      do_frame(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 1'b1, "rand");
    req = 4'b0000;
    tick();

    // Reset during the last data bit.
    scramble_l();
    req = 4'b0101;
    p = rr_pick(req);
    oh = 4'b0001 << p;
    tick();
    req = 4'b0000;
    repeat (6) tick();
    chk("prerst_pb", 8'(PB), 8'(oh));
    chk("prerst_lb", 8'(LB), 8'd3);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ser",  8'(serout), 8'd0);
    chk("midrst_busy", 8'(busy),   8'd0);
    chk("midrst_pb",   8'(PB),     8'd0);
    chk("midrst_lb",   8'(LB),     8'd0);
    rr_last = 3;
    tick();
    chk("midrst_hold_busy", 8'(busy), 8'd0);
    rst = 1'b1;
    do_frame(4'b0010, 4'b0000, 1'b0, "afterrst");
    do_frame(4'b1001, 4'b0000, 1'b0, "afterrst_rr");

    // Zero-gap instance: held request gives starts 8 cycles apart.
    scramble_l();
    d  = ld[0];
    fb = frame_bits(0, d);
    reqz = 4'b0001;
    for (int f = 0; f < 3; f++) begin
      tick();
      for (int j = 0; j < 7; j++) begin
        chk("gap0_ser",  8'(seroutz), 8'(fb[j]));
        chk("gap0_ack",  8'(ackz),    (j == 0) ? 8'd1 : 8'd0);
        chk("gap0_busy", 8'(busyz),   8'd1);
        chk("gap0_lb",   8'(LBz),     (j >= 3) ? 8'(j - 3) : 8'd0);
        if (j < 6) tick();
      end
      tick();
      chk("gap0_idle_busy", 8'(busyz),   8'd0);
      chk("gap0_idle_ser",  8'(seroutz), 8'd0);
      chk("gap0_idle_ack",  8'(ackz),    8'd0);
    end
    reqz = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
